// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the GPR writeback arbiter.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    // One buffered long-latency result; valid=0 marks a squashed (dead) entry.
    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

    // True when a decode source register is non-zero and equals the given address.
    function automatic logic addr_hit(input logic [REG_ADDR_WIDTH-1:0] query,
                                      input logic [REG_ADDR_WIDTH-1:0] address);
        return (query != REG_ZERO) && (query == address);
    endfunction

endpackage

// File: rtl/wb_pending_fifo.sv
// Circular buffer of long-latency results with per-entry squash by address
// and address-match query ports for decode pending detection.
module wb_pending_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    input  logic                      squash_enable,
    input  logic [REG_ADDR_WIDTH-1:0] squash_address,
    input  logic [REG_ADDR_WIDTH-1:0] query_address_1,
    input  logic [REG_ADDR_WIDTH-1:0] query_address_2,
    output wb_entry_t                 head_entry,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      match_1,
    output logic                      match_2
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    // A valid bit is 1 only for an occupied, unsquashed slot; popped slots are
    // cleared so the match logic never needs an occupancy mask.
    logic [DEPTH-1:0]          valid_reg;
    logic [DEPTH-1:0]          valid_next;
    logic [REG_ADDR_WIDTH-1:0] address_reg [DEPTH];
    logic [DATA_WIDTH-1:0]     data_reg    [DEPTH];
    logic [PTR_WIDTH-1:0]      wr_ptr_reg;
    logic [PTR_WIDTH-1:0]      rd_ptr_reg;
    logic [PTR_WIDTH:0]        count_reg;
    logic [PTR_WIDTH:0]        count_next;
    logic [DEPTH-1:0]          hit_1;
    logic [DEPTH-1:0]          hit_2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_WIDTH-1:0] SLOT = PTR_WIDTH'(gi);

            // A fresh push wins; otherwise pop or a younger pipeline write kills the entry.
            assign valid_next[gi] = (push && (wr_ptr_reg == SLOT)) ? push_entry.valid :
                                    (valid_reg[gi]
                                     && !(pop && (rd_ptr_reg == SLOT))
                                     && !(squash_enable && (address_reg[gi] == squash_address)));

            assign hit_1[gi] = valid_reg[gi] && (address_reg[gi] == query_address_1);
            assign hit_2[gi] = valid_reg[gi] && (address_reg[gi] == query_address_2);
        end
    endgenerate

    // Occupancy changes by at most one per cycle; push and pop together cancel.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Control state: valid bits, pointers and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Payload storage; contents are meaningless while the slot's valid bit is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            address_reg[wr_ptr_reg] <= push_entry.address;
            data_reg[wr_ptr_reg]    <= push_entry.data;
        end
    end

    assign head_entry = '{valid:   valid_reg[rd_ptr_reg],
                          address: address_reg[rd_ptr_reg],
                          data:    data_reg[rd_ptr_reg]};
    assign count      = count_reg;
    assign match_1    = |hit_1;
    assign match_2    = |hit_2;

endmodule

// File: rtl/writeback_arbiter.sv
// Sole driver of the GPR write port: pipeline writeback has priority, buffered
// long-latency results fill idle slots; provides pending flags and bypass.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      system_clock,
    input  logic                      system_reset_n,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_address,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      lu_valid,
    output logic                      lu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] lu_address,
    input  logic [DATA_WIDTH-1:0]     lu_data,
    output logic                      gpr_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] gpr_write_address,
    output logic [DATA_WIDTH-1:0]     gpr_write_data,
    input  logic [REG_ADDR_WIDTH-1:0] query_address_1,
    input  logic [REG_ADDR_WIDTH-1:0] query_address_2,
    output logic                      pending_1,
    output logic                      pending_2,
    output logic                      bypass_valid_1,
    output logic                      bypass_valid_2,
    output logic [DATA_WIDTH-1:0]     bypass_data_1,
    output logic [DATA_WIDTH-1:0]     bypass_data_2,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;

    logic      wb_active;
    logic      lu_accept;
    logic      fifo_push;
    logic      fifo_pop;
    wb_entry_t push_entry;
    wb_entry_t head_entry;
    logic      match_1;
    logic      match_2;

    // Writes to r0 are dropped, so such a wb cycle is treated as idle.
    assign wb_active = wb_valid && (wb_address != REG_ZERO);

    // Ready looks only at the registered count, never at this cycle's pop.
    assign lu_ready  = (fifo_count < CNT_WIDTH'(DEPTH));
    assign lu_accept = lu_valid && lu_ready;
    assign fifo_push = lu_accept && (lu_address != REG_ZERO);

    // A same-cycle pipeline write to the same register makes the new entry dead on arrival.
    assign push_entry = '{valid:   !(wb_active && (wb_address == lu_address)),
                          address: lu_address,
                          data:    lu_data};

    // Squashed heads drain in any cycle; a live head only when the pipeline is idle.
    assign fifo_pop = (fifo_count != '0) && (!head_entry.valid || !wb_active);

    wb_pending_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk             (system_clock),
        .rst_n           (system_reset_n),
        .push            (fifo_push),
        .push_entry      (push_entry),
        .pop             (fifo_pop),
        .squash_enable   (wb_active),
        .squash_address  (wb_address),
        .query_address_1 (query_address_1),
        .query_address_2 (query_address_2),
        .head_entry      (head_entry),
        .count           (fifo_count),
        .match_1         (match_1),
        .match_2         (match_2)
    );

    // Priority write mux; nothing reaches the register file while reset is held.
    always_comb begin
        gpr_write_enable  = 1'b0;
        gpr_write_address = REG_ZERO;
        gpr_write_data    = '0;
        if (system_reset_n) begin
            if (wb_active) begin
                gpr_write_enable  = 1'b1;
                gpr_write_address = wb_address;
                gpr_write_data    = wb_data;
            end else if (head_entry.valid) begin
                gpr_write_enable  = 1'b1;
                gpr_write_address = head_entry.address;
                gpr_write_data    = head_entry.data;
            end
        end
    end

    // Pending covers live buffered entries plus a result being accepted right now.
    always_comb begin
        pending_1 = 1'b0;
        pending_2 = 1'b0;
        if (system_reset_n) begin
            pending_1 = (query_address_1 != REG_ZERO)
                        && (match_1 || (lu_accept && (lu_address == query_address_1)));
            pending_2 = (query_address_2 != REG_ZERO)
                        && (match_2 || (lu_accept && (lu_address == query_address_2)));
        end
    end

    // Register-file reads are combinational, so forward the write in flight.
    always_comb begin
        bypass_valid_1 = gpr_write_enable && addr_hit(query_address_1, gpr_write_address);
        bypass_valid_2 = gpr_write_enable && addr_hit(query_address_2, gpr_write_address);
        bypass_data_1  = gpr_write_data;
        bypass_data_2  = gpr_write_data;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             system_clock = 1'b0;
    logic             system_reset_n;
    logic             wb_valid;
    logic [4:0]       wb_address;
    logic [31:0]      wb_data;
    logic             lu_valid;
    logic             lu_ready;
    logic [4:0]       lu_address;
    logic [31:0]      lu_data;
    logic             gpr_write_enable;
    logic [4:0]       gpr_write_address;
    logic [31:0]      gpr_write_data;
    logic [4:0]       query_address_1;
    logic [4:0]       query_address_2;
    logic             pending_1;
    logic             pending_2;
    logic             bypass_valid_1;
    logic             bypass_valid_2;
    logic [31:0]      bypass_data_1;
    logic [31:0]      bypass_data_2;
    logic [CNT_W-1:0] fifo_count;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .system_clock      (system_clock),
        .system_reset_n    (system_reset_n),
        .wb_valid          (wb_valid),
        .wb_address        (wb_address),
        .wb_data           (wb_data),
        .lu_valid          (lu_valid),
        .lu_ready          (lu_ready),
        .lu_address        (lu_address),
        .lu_data           (lu_data),
        .gpr_write_enable  (gpr_write_enable),
        .gpr_write_address (gpr_write_address),
        .gpr_write_data    (gpr_write_data),
        .query_address_1   (query_address_1),
        .query_address_2   (query_address_2),
        .pending_1         (pending_1),
        .pending_2         (pending_2),
        .bypass_valid_1    (bypass_valid_1),
        .bypass_valid_2    (bypass_valid_2),
        .bypass_data_1     (bypass_data_1),
        .bypass_data_2     (bypass_data_2),
        .fifo_count        (fifo_count)
    );

    always #5 system_clock = ~system_clock;

    // Reference model: ordered list of buffered results, oldest first.
    typedef struct {
        bit          valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } m_entry_t;

    m_entry_t    model_q[$];
    logic [4:0]  drain_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_transfers = 0;
    bit          last_lu_accept = 0;
    string       phase = "init";

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
        end
    endtask

    function automatic bit model_pending(logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (model_q[i])
            if (model_q[i].valid && model_q[i].addr == q) return 1'b1;
        return lu_valid && (model_q.size() < DEPTH) && (lu_address == q);
    endfunction

    // Compare every output against the model for the current inputs.
    task automatic check_model();
        bit          wb_act;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        wb_act = wb_valid && (wb_address != 5'd0);
        e_we = 1'b0; e_a = 5'd0; e_d = 32'd0;
        if (wb_act) begin
            e_we = 1'b1; e_a = wb_address; e_d = wb_data;
        end else if (model_q.size() > 0 && model_q[0].valid) begin
            e_we = 1'b1; e_a = model_q[0].addr; e_d = model_q[0].data;
        end
        chk("lu_ready", 32'(lu_ready), 32'(model_q.size() < DEPTH));
        chk("fifo_count", 32'(fifo_count), 32'(model_q.size()));
        chk("gpr_we", 32'(gpr_write_enable), 32'(e_we));
        chk("gpr_addr", 32'(gpr_write_address), 32'(e_a));
        chk("gpr_data", gpr_write_data, e_d);
        chk("pending_1", 32'(pending_1), 32'(model_pending(query_address_1)));
        chk("pending_2", 32'(pending_2), 32'(model_pending(query_address_2)));
        chk("bypass_v1", 32'(bypass_valid_1), 32'(e_we && query_address_1 != 0 && e_a == query_address_1));
        chk("bypass_v2", 32'(bypass_valid_2), 32'(e_we && query_address_2 != 0 && e_a == query_address_2));
        chk("bypass_d1", bypass_data_1, e_d);
        chk("bypass_d2", bypass_data_2, e_d);
        $display("[%0t] %s wb=%0b/r%0d lu=%0b/r%0d cnt=%0d we=%0b r%0d=%h", $time, phase,
                 wb_valid, wb_address, lu_valid, lu_address, fifo_count,
                 gpr_write_enable, gpr_write_address, gpr_write_data);
    endtask

    // Apply the clock edge to the model using the inputs held this cycle.
    task automatic update_model();
        bit wb_act;
        bit acc;
        wb_act = wb_valid && (wb_address != 5'd0);
        acc    = lu_valid && (model_q.size() < DEPTH);
        last_lu_accept = acc;
        if (acc) n_transfers++;
        if (model_q.size() > 0 && (!model_q[0].valid || !wb_act)) void'(model_q.pop_front());
        if (wb_act)
            foreach (model_q[i])
                if (model_q[i].addr == wb_address) model_q[i].valid = 1'b0;
        if (acc && lu_address != 5'd0)
            model_q.push_back('{valid: !(wb_act && wb_address == lu_address),
                                addr: lu_address, data: lu_data});
    endtask

    task automatic sample();
        @(negedge system_clock);
        check_model();
    endtask

    task automatic advance();
        update_model();
        @(posedge system_clock);
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        int idx;
        int c;
        system_reset_n = 1'b0;
        wb_valid = 0; wb_address = 0; wb_data = 0;
        lu_valid = 0; lu_address = 0; lu_data = 0;
        query_address_1 = 0; query_address_2 = 0;

        // Reset then idle.
        phase = "reset";
        #3;
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd1);
        chk("rst_we", 32'(gpr_write_enable), 32'd0);
        #9 system_reset_n = 1'b1;
        @(posedge system_clock); #1;
        cyc(); cyc();

        // Single long-latency result, minimum latency 1.
        phase = "single";
        lu_valid = 1; lu_address = 5; lu_data = 32'hDEADBEEF;
        query_address_1 = 5; query_address_2 = 6;
        sample();
        chk("pend_accept", 32'(pending_1), 32'd1);
        advance();
        lu_valid = 0;
        sample();
        chk("write_r5", gpr_write_data, 32'hDEADBEEF);
        chk("bypass_r5", 32'(bypass_valid_1), 32'd1);
        advance();
        sample();
        chk("pend_clear", 32'(pending_1), 32'd0);
        advance();

        // Pipeline busy 6 cycles while 5 results are offered.
        phase = "backpressure";
        idx = 0; c = 0;
        query_address_1 = 11; query_address_2 = 14;
        while ((idx < 5 || model_q.size() != 0 || c < 6) && c < 40) begin
            wb_valid = (c < 6); wb_address = 5'(c + 1); wb_data = $urandom();
            lu_valid = (idx < 5); lu_address = 5'(10 + idx); lu_data = 32'h100 + 32'(idx);
            sample();
            if (c == 4) chk("full_not_ready", 32'(lu_ready), 32'd0);
            if (!wb_valid && gpr_write_enable) drain_q.push_back(gpr_write_address);
            advance();
            if (last_lu_accept) idx++;
            c++;
        end
        wb_valid = 0; lu_valid = 0;
        chk("drain_len", 32'(drain_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < drain_q.size(); k++)
            chk("drain_order", 32'(drain_q[k]), 32'(10 + k));

        // WAW squash of a buffered entry by a younger pipeline write.
        phase = "squash";
        query_address_1 = 7; query_address_2 = 0;
        lu_valid = 1; lu_address = 7; lu_data = 32'h11;
        cyc();
        lu_valid = 0;
        wb_valid = 1; wb_address = 7; wb_data = 32'h22;
        sample();
        chk("wb_r7_data", gpr_write_data, 32'h22);
        chk("pend_before", 32'(pending_1), 32'd1);
        advance();
        wb_valid = 0;
        sample();
        chk("squash_nowrite", 32'(gpr_write_enable), 32'd0);
        chk("squash_count", 32'(fifo_count), 32'd1);
        chk("squash_pend", 32'(pending_1), 32'd0);
        advance();
        sample();
        chk("squash_empty", 32'(fifo_count), 32'd0);
        advance();

        // Register 0 from both sources.
        phase = "reg0";
        query_address_1 = 0; query_address_2 = 0;
        lu_valid = 1; lu_address = 0; lu_data = 32'h55;
        wb_valid = 1; wb_address = 0; wb_data = 32'h66;
        sample();
        chk("r0_we", 32'(gpr_write_enable), 32'd0);
        advance();
        lu_valid = 0; wb_valid = 0;
        sample();
        chk("r0_count", 32'(fifo_count), 32'd0);
        advance();

        // Fill to full, then drain with lu_valid held (simultaneous push/pop).
        phase = "full";
        idx = 0;
        query_address_1 = 21; query_address_2 = 24;
        for (c = 0; c < 40 && (c < 4 || idx < 12); c++) begin
            wb_valid = (c < 4); wb_address = 1; wb_data = $urandom();
            lu_valid = 1; lu_address = 5'(20 + (idx % 8)); lu_data = $urandom();
            cyc();
            if (last_lu_accept) idx++;
        end
        lu_valid = 0; wb_valid = 0;
        for (c = 0; c < 6; c++) cyc();

        // Random traffic over a small register range to force collisions and wraps.
        phase = "random";
        n_transfers = 0;
        last_lu_accept = 1;
        for (c = 0; c < 400; c++) begin
            wb_valid = 1'($urandom_range(0, 1));
            wb_address = 5'($urandom_range(0, 7));
            wb_data = $urandom();
            if (!lu_valid || last_lu_accept) begin
                lu_valid = ($urandom_range(0, 2) != 0);
                lu_address = 5'($urandom_range(0, 7));
                lu_data = $urandom();
            end
            query_address_1 = 5'($urandom_range(0, 7));
            query_address_2 = 5'($urandom_range(0, 7));
            cyc();
        end
        chk("wrap_transfers", 32'(n_transfers >= 3 * DEPTH), 32'd1);
        lu_valid = 0; wb_valid = 0;
        for (c = 0; c < 8; c++) cyc();

        // Asynchronous reset in the middle of a drain.
        phase = "reset_mid";
        idx = 0;
        for (c = 0; c < 20 && idx < 3; c++) begin
            wb_valid = 1; wb_address = 1; wb_data = $urandom();
            lu_valid = 1; lu_address = 5'(8 + idx); lu_data = $urandom();
            cyc();
            if (last_lu_accept) idx++;
        end
        lu_valid = 0; wb_valid = 0;
        query_address_1 = 9; query_address_2 = 10;
        sample();
        chk("pre_reset_count", 32'(fifo_count), 32'd3);
        #2;
        system_reset_n = 0;
        wb_valid = 1; wb_address = 3; wb_data = 32'hABCD;
        #1;
        chk("async_count", 32'(fifo_count), 32'd0);
        chk("async_we", 32'(gpr_write_enable), 32'd0);
        chk("async_ready", 32'(lu_ready), 32'd1);
        chk("async_pend", 32'(pending_1), 32'd0);
        chk("async_bypass", 32'(bypass_valid_1), 32'd0);
        @(posedge system_clock); #1;
        chk("hold_we", 32'(gpr_write_enable), 32'd0);
        chk("hold_count", 32'(fifo_count), 32'd0);
        @(negedge system_clock); #2;
        wb_valid = 0;
        system_reset_n = 1;
        model_q.delete();
        @(posedge system_clock); #1;
        phase = "post_reset";
        for (c = 0; c < 5; c++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sole driver of the general purpose register file write port.
- Merges two result sources:
  - the in-order pipeline writeback stream, which has priority and is never stalled;
  - the long-latency unit (mult/div) result stream, which uses a valid/ready handshake.
- Long-latency results are buffered in a small FIFO and drained into idle write slots.
- Supplies decode with pending-register flags (stall) and same-cycle write bypass, because register-file reads are combinational and miss the write in flight.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)

Ports:
system_clock  input  1  clock; all state updates on rising edge
system_reset_n  input  1  asynchronous active-low reset
wb_valid  input  1  pipeline writeback request this cycle; always accepted
wb_address  input  5  pipeline destination register
wb_data  input  32  pipeline result
lu_valid  input  1  long-latency result offered
lu_ready  output  1  FIFO can accept; transfer when lu_valid && lu_ready
lu_address  input  5  long-latency destination register
lu_data  input  32  long-latency result
gpr_write_enable  output  1  to register file write_enable
gpr_write_address  output  5  to register file write address
gpr_write_data  output  32  to register file write data
query_address_1, query_address_2  input  5  decode source registers
pending_1, pending_2  output  1  source awaits a buffered long-latency result
bypass_valid_1, bypass_valid_2  output  1  source is being written this cycle
bypass_data_1, bypass_data_2  output  32  value being written
fifo_count  output  log2(DEPTH)+1  occupied entries, including squashed ones

Behaviour:
- Reset (asynchronous, active low): FIFO empty, all entry valid bits 0, pointers 0, fifo_count=0, lu_ready=1, gpr_write_enable=0, gpr_write_address=0, gpr_write_data=0, pending_x=0, bypass_valid_x=0, bypass_data_x=0.
- Reset mid-operation discards all buffered results; no write is issued during reset.
- Register 0: any write addressed to 0 is dropped.
  - A wb write to 0 counts as an idle slot.
  - An lu transfer to 0 is handshaked but not enqueued.
- Write mux (combinational):
  - If wb_valid && wb_address!=0, drive the wb write.
  - Else if the FIFO head is valid, drive the head write and pop it.
  - Else gpr_write_enable=0, with address and data driven 0.
- Squashed head: a head whose valid bit is 0 is popped silently in any cycle, even under a wb write. It produces no GPR write.
- Enqueue:
  - lu_ready = (fifo_count < DEPTH). It depends only on the registered count; there is no combinational path from pop.
  - An accepted entry is written at the tail on the clock edge.
  - Earliest GPR write is the cycle after acceptance (minimum latency 1).
- Simultaneous push and pop are allowed; fifo_count is unchanged.
- Full: lu_ready=0. The lu source must hold lu_valid, lu_address and lu_data stable until accepted.
- WAW squash: a pipeline write (wb_valid, wb_address!=0) is younger than every buffered entry.
  - On that edge, clear the valid bit of every FIFO entry whose address matches wb_address.
  - An lu result accepted in the same cycle with the same address is also enqueued squashed.
- Pending:
  - pending_x=1 if query_address_x!=0 and either (a) any valid FIFO entry matches it, or (b) lu_valid && lu_ready && lu_address matches it.
  - A matching entry being popped this cycle still asserts pending_x, together with bypass.
- Bypass: bypass_valid_x = gpr_write_enable && query_address_x!=0 && gpr_write_address==query_address_x. bypass_data_x = gpr_write_data.
- Pointers wrap modulo DEPTH; fifo_count saturates structurally at DEPTH.

Decomposition:
- Shared package:
  - REG_ADDR_WIDTH=5
  - DATA_WIDTH=32
  - REG_ZERO=5'd0
  - typedef wb_entry_t {valid, address[4:0], data[31:0]}
- One sub-module, wb_pending_fifo. It holds the circular buffer, the per-entry squash-by-address port and the address-match query ports.
- The top level holds the priority mux and the bypass logic.

Test Plan:
- Reset then idle -> lu_ready=1, fifo_count=0, gpr_write_enable=0. Assert reset mid-drain with 3 entries -> count=0 immediately and no further writes.
- lu r5=0xDEADBEEF with wb idle -> pending_1 (query 5)=1 in the acceptance cycle; next cycle gpr_write r5=0xDEADBEEF and bypass_valid_1=1; the following cycle pending_1=0.
- wb_valid held on r1..r6 for 6 cycles while lu pushes 5 results -> 4 accepted, lu_ready=0 on the 5th. After wb goes idle, 4 drains in FIFO order; the 5th is accepted when count<4.
- Buffer lu r7=0x11, then wb r7=0x22 -> GPR gets r7=0x22 only, and the squashed entry pops with no write. fifo_count goes 1->0 and pending for r7 drops the cycle after the wb write.
- lu r0=0x55 and wb r0=0x66 -> no GPR write, nothing enqueued, pending/bypass stay 0 for query 0.
- Full FIFO with wb idle, lu_valid held -> push and pop in the same edge once ready, count stays DEPTH-1/DEPTH as expected. Wrap-around is verified over 3×DEPTH transfers with data integrity.
